// File: rtl/mult_operand_sequencer.sv
// rtl/mult_operand_sequencer.sv - operand unpack/sequencer feeding a combinational 24x24 mantissa multiplier
//
// Accepts two IEEE-754 single operands on a valid/ready handshake.
// Unpacks each operand into sign, exponent and a 24-bit mantissa. Denormals are flushed to zero.
// Holds mant1/mant2 stable for the external multiplier.
// After SETTLE_CYCLES it captures prod_in together with the result sign and the biased exponent sum.
// The captured result is presented on a valid/ready handshake.
//
// Optional feature macro: SPECIAL_BYPASS_EN
//   When defined, zero/inf/NaN operands skip the settle wait.
//   A canned result is then presented the cycle after accept, and special reports the class.
//   When undefined, every operation settles and special is always 2'b00.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   a_in, b_in        operands (IEEE-754 single)
//   in_valid/in_ready operand handshake
//   mant1, mant2      24-bit mantissas to multiplier in1/in2
//   prod_in           32-bit product from multiplier out
//   res               captured product word (or canned special result)
//   sign_out          result sign
//   exp_sum           ea + eb - EXP_BIAS, 10-bit two's complement
//   special           00 normal, 01 zero, 10 NaN, 11 infinity
//   res_valid/res_ready result handshake
module mult_operand_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int EXP_BIAS      = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] mant1,
    output logic [23:0] mant2,
    input  logic [31:0] prod_in,
    output logic [31:0] res,
    output logic        sign_out,
    output logic [9:0]  exp_sum,
    output logic [1:0]  special,
    output logic        res_valid,
    input  logic        res_ready
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [15:0] CNT_LAST = 16'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;

    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        sign_ab;
    logic [9:0]  exp_ab;

    assign ea      = a_in[30:23];
    assign eb      = b_in[30:23];
    assign fa      = a_in[22:0];
    assign fb      = b_in[22:0];
    assign sign_ab = a_in[31] ^ b_in[31];
    assign exp_ab  = {2'b00, ea} + {2'b00, eb} - 10'(EXP_BIAS);

    // Combinational so reset assertion drops it immediately.
    assign in_ready = (state == IDLE) && !rst;

`ifdef SPECIAL_BYPASS_EN
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic is_nan, is_inf, is_zero;

    // Zero includes denormals because they are flushed.
    assign a_zero  = (ea == 8'h00);
    assign b_zero  = (eb == 8'h00);
    assign a_inf   = (ea == 8'hFF) && (fa == 23'h0);
    assign b_inf   = (eb == 8'hFF) && (fb == 23'h0);
    assign a_nan   = (ea == 8'hFF) && (fa != 23'h0);
    assign b_nan   = (eb == 8'hFF) && (fb != 23'h0);
    assign is_nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    assign is_inf  = a_inf || b_inf;
    assign is_zero = a_zero || b_zero;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mant1     <= '0;
            mant2     <= '0;
            res       <= '0;
            sign_out  <= 1'b0;
            exp_sum   <= '0;
            special   <= 2'b00;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mant1    <= (ea == 8'h00) ? 24'h0 : {1'b1, fa};
                        mant2    <= (eb == 8'h00) ? 24'h0 : {1'b1, fb};
                        sign_out <= sign_ab;
                        exp_sum  <= exp_ab;
                        cnt      <= '0;
`ifdef SPECIAL_BYPASS_EN
                        // NaN outranks infinity, which outranks zero.
                        if (is_nan) begin
                            res       <= 32'h7FC0_0000;
                            special   <= 2'b10;
                            res_valid <= 1'b1;
                            state     <= HOLD;
                        end else if (is_inf) begin
                            res       <= {sign_ab, 8'hFF, 23'h0};
                            special   <= 2'b11;
                            res_valid <= 1'b1;
                            state     <= HOLD;
                        end else if (is_zero) begin
                            res       <= {sign_ab, 31'h0};
                            special   <= 2'b01;
                            res_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            state <= SETTLE;
                        end
`else
                        state <= SETTLE;
`endif
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == CNT_LAST) begin
                        res       <= prod_in;
                        special   <= 2'b00;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
